// File: rtl/data_memory.sv
// Word-organised data memory with a configurable number of wait states.
// Drives a wait_sig stall handshake and a one-cycle access_err pulse.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_data_sig,
  input  logic        write_data_sig,
  output logic [31:0] read_data,
  output logic        wait_sig,
  output logic        access_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int unsigned CNT_LOAD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_write;
  logic               r_oor;
  logic               r_both;

  logic [31:0]        r_read_data;
  logic               r_access_err;

  logic               w_req;
  logic [IDX_W-1:0]   w_addr_idx;
  logic               w_addr_oor;
  logic               w_unused;

  logic               w_accept;
  logic               w_do_access;
  logic               w_abort;
  logic [IDX_W-1:0]   w_acc_idx;
  logic [31:0]        w_acc_wdata;
  logic               w_acc_write;
  logic               w_acc_oor;
  logic               w_acc_both;

  logic [31:0]        mem [DEPTH_WORDS];

  assign w_req      = read_data_sig | write_data_sig;
  assign w_addr_idx = address[IDX_W+1:2];
  assign w_addr_oor = (address[31:2] >= 30'(DEPTH_WORDS));
  assign w_unused   = ^address[1:0];

  assign wait_sig   = ((r_state == S_IDLE) && w_req) || (r_state == S_BUSY);
  assign read_data  = r_read_data;
  assign access_err = r_access_err;

  // State and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; the access uses live inputs when performed on the accept edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    w_abort     = 1'b0;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_write = r_write;
    w_acc_oor   = r_oor;
    w_acc_both  = r_both;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_acc_idx   = w_addr_idx;
          w_acc_wdata = write_data;
          w_acc_write = write_data_sig;
          w_acc_oor   = w_addr_oor;
          w_acc_both  = read_data_sig & write_data_sig;
          if (WAIT_CYCLES == 0) begin
            w_do_access = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_cnt_nxt   = CNT_W'(CNT_LOAD);
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!w_req) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_do_access = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latched request, load data and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_oor        <= 1'b0;
      r_both       <= 1'b0;
      r_read_data  <= '0;
      r_access_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_acc_idx;
        r_wdata <= w_acc_wdata;
        r_write <= w_acc_write;
        r_oor   <= w_acc_oor;
        r_both  <= w_acc_both;
      end
      if (w_do_access && !w_acc_write) begin
        r_read_data <= w_acc_oor ? 32'd0 : mem[w_acc_idx];
      end
      r_access_err <= (w_do_access && (w_acc_oor || w_acc_both)) || w_abort;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_write && !w_acc_oor) begin
      mem[w_acc_idx] <= w_acc_wdata;
    end
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory that responds to the core's data-port request signals (`address`, `write_data`, `read_data_sig`, `write_data_sig`) and returns `read_data` plus a `wait_sig` stall indication.

- Sits on the core's data side and replaces the tied-off `wait_sig` with a real handshake.
- Models a synchronous RAM with a configurable number of wait states, so the core's stall path can be exercised.
- Reports out-of-range and illegal requests on a one-cycle error pulse.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, default 2: extra stall cycles per access; 0 is legal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `address` in 32: byte address from the core.
- `write_data` in 32: store data.
- `read_data_sig` in 1: read request, level.
- `write_data_sig` in 1: write request, level.
- `read_data` out 32: load data, registered.
- `wait_sig` out 1: stall; the core holds its request and PC while this is high.
- `access_err` out 1: one-cycle error pulse.

## Operation
- Word index is `address[$clog2(DEPTH_WORDS)+1:2]`. `address[1:0]` is ignored: word access only, no byte lanes.
- Out of range means `address[31:2] >= DEPTH_WORDS`.
- The state machine has three states: IDLE, BUSY, ACK. Down-counter width is `$clog2(WAIT_CYCLES+1)` (min 1).
- A request is present when `read_data_sig | write_data_sig`.
- **IDLE, no request:** stay in IDLE.
- **IDLE, request present (accept):**
  - Latch the word index, `write_data`, and kind. If both sigs are high, the kind is write and an error is flagged.
  - If `WAIT_CYCLES==0`, perform the access on this edge and go to ACK.
  - Otherwise load the counter with `WAIT_CYCLES-1` and go to BUSY.
- **BUSY, request still present:**
  - If counter == 0, perform the access and go to ACK.
  - Otherwise decrement the counter.
  - Changes to `address` or `write_data` during BUSY are ignored; the latched values are used.
- **BUSY, request dropped (abort):** go to IDLE. No write is committed, `read_data` is unchanged, and `access_err` pulses next cycle.
- **ACK:** always go to IDLE. The request is ignored, since it is the same request the core is completing. A new request is accepted no earlier than the cycle after ACK.
- **Performing the access:**
  - Write, in range: `mem[idx] <= wdata`.
  - Read, in range: `read_data <= mem[idx]`.
  - Out of range: write dropped, `read_data <= 0`. `access_err` is high during ACK.
  - Both sigs high: `access_err` is high during ACK.
- `wait_sig` is combinational: `(state==IDLE & request) | state==BUSY`. It is low in ACK and in IDLE without a request.
- `read_data` holds its value until the next completed read. It is defined to the core only during ACK.
- Memory contents are not reset and are undefined at power-up.

## Timing
- **Reset values:** state IDLE, counter 0, `read_data` 0, `access_err` 0. `wait_sig` follows the combinational rule, so it is 0 unless a request is present.
- Asserting `rst_n` low mid-BUSY returns the block to IDLE immediately (asynchronous). The pending write is never committed.
- **Latency:** a request first seen in cycle 0 gives `wait_sig` high for cycles 0..`WAIT_CYCLES` and ACK in cycle `WAIT_CYCLES+1`.
  - Write commit and `read_data` update happen on the edge entering ACK.
- **Throughput:** one access per `WAIT_CYCLES+2` cycles. The IDLE cycle after ACK is mandatory.
- `access_err` is asserted for exactly one cycle:
  - in ACK for out-of-range or both-sigs requests;
  - in the cycle after an abort, for an abort.
- A read immediately following a write to the same word returns the new data, since the write committed at an earlier edge.

## Test plan
- **Write then read, `WAIT_CYCLES=2`:** write 0xDEADBEEF to 0x10 at cycle 0. Expect `wait_sig` high for cycles 0–2, low in cycle 3, then IDLE in cycle 4. Read 0x10 starting in cycle 5; expect `read_data`=0xDEADBEEF in cycle 8 and `access_err`=0 throughout.
- **`WAIT_CYCLES=0`, back-to-back:** write 0x1 to 0x0, then read 0x0. Expect `wait_sig` high exactly one cycle per access, ACK every second cycle, and `read_data`=0x1.
- **Out of range, `DEPTH_WORDS=1024`:** write 0xFFFFFFFF to 0x1000, then read 0x1000. Expect `access_err` pulsing in each ACK and `read_data`=0. Word 0 must still read its prior value, confirming no alias wrap.
- **Both sigs high:** raise both sigs at 0x20 with `write_data`=0x55. Expect the write committed, `read_data` unchanged, and `access_err` high in ACK.
- **Abort:** drop `write_data_sig` during BUSY of a write of 0xAA to 0x30. Expect a return to IDLE, `access_err` pulsing next cycle, and a later read of 0x30 returning the old value.
- **Reset mid-BUSY:** pulse `rst_n` low during BUSY of a write to 0x40. Expect IDLE and `read_data`=0 immediately, `wait_sig`=0, and memory at 0x40 unchanged.
